mnk_game: RTL and testbench
===========================

MNK_GAME -- requirements
Module: mnk_game

Interface
REQ-001 Parameter N, default 3, board side length, legal range 3..8.
REQ-002 Parameter K, default 3, stones in a row needed to win, legal range 3..N.
REQ-003 Parameter CW, default 3, coordinate width; SHALL satisfy 2^CW >= N.
REQ-004 clk  in  1  clock, all state updates on the rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 move_valid  in  1  move request.
REQ-007 move_ready  out  1  block can accept a move.
REQ-008 move_side  in  1  side moving: 0 = PLAYER, 1 = COMPUTER.
REQ-009 move_row, move_col  in  CW each  target cell.
REQ-010 clear  in  1  synchronous new-game request.
REQ-011 rd_row, rd_col  in  CW each  cell read address.
REQ-012 rd_cell  out  2  combinational cell content: 00 EMPTY, 01 PLAYER, 10 COMPUTER.
REQ-013 illegal_move  out  1  one-cycle pulse flagging a rejected move.
REQ-014 illegal_code  out  2  reject reason: 01 off-board, 10 occupied, 11 wrong turn; held until the next handshake.
REQ-015 win  out  1  game won.
REQ-016 winner  out  2  winning side code; 00 when win=0.
REQ-017 tie  out  1  board full with no winner.
REQ-018 move_count  out  7  stones placed.
REQ-019 next_side  out  1  side expected to move next.

Function
REQ-020 The FSM SHALL have states IDLE, CHECK and OVER; move_ready SHALL be 1 only in IDLE.
REQ-021 A handshake (move_valid & move_ready) SHALL apply checks in this priority: row or col >= N gives off-board; a non-EMPTY cell gives occupied; move_side != next_side gives wrong turn.
REQ-022 On a rejected move, illegal_move SHALL pulse 1 the following cycle, the board SHALL be unchanged, and the FSM SHALL stay in IDLE.
REQ-023 On an accepted move, the cell SHALL be written, move_count SHALL increment, next_side SHALL toggle, illegal_code SHALL become 00, and the FSM SHALL go to CHECK.
REQ-024 CHECK SHALL scan the four lines through the last move (row, column, diagonal, anti-diagonal).
REQ-025 For each line, CHECK SHALL walk one cell per cycle in the positive then the negative direction, stopping at the board edge or a non-matching cell; run length SHALL include the placed stone.
REQ-026 CHECK SHALL terminate as soon as any run reaches K; worst-case CHECK length SHALL be <= 8*(K-1) cycles.
REQ-027 Run >= K SHALL go to OVER with win=1 and winner = code of the moving side.
REQ-028 No win with move_count = N*N SHALL go to OVER with tie=1.
REQ-029 Any other CHECK result SHALL return to IDLE.
REQ-030 win and tie SHALL never both be 1.
REQ-031 In OVER, moves SHALL be ignored without flagging (move_ready=0).
REQ-032 clear SHALL, in any state, empty the board, zero move_count, win, winner, tie and illegal_code, set next_side=0, and go to IDLE next cycle.
REQ-033 clear SHALL override a simultaneous move_valid.
REQ-034 The block SHALL never drive win or tie from a partially written board.

Reset
REQ-035 rstn low SHALL immediately force: all cells EMPTY, FSM=IDLE, move_ready=1, illegal_move=0, illegal_code=00, win=0, winner=00, tie=0, move_count=0, next_side=0.
REQ-036 Reset asserted during CHECK SHALL abandon the scan with no residual flags.

Configuration
REQ-037 Macro MNK_GAME_UNDO_EN SHALL control the undo feature.
REQ-038 With MNK_GAME_UNDO_EN defined, input undo (1 bit) SHALL be present.
REQ-039 With the macro defined, undo in IDLE or OVER, with move_count > 0 and no move handshake that cycle, SHALL clear the last-placed cell, decrement move_count, toggle next_side, clear win, winner and tie, and go to IDLE; only one level of undo is supported, and a second undo without an intervening move SHALL be ignored.
REQ-040 Without the macro, the undo port and the last-move history registers SHALL be absent.

Verification
REQ-041 N=3, K=3: P(0,0) C(1,0) P(0,1) C(1,1) P(0,2) -> after CHECK, win=1, winner=01, move_ready=0.
REQ-042 N=3: P(1,1), then C(1,1) -> illegal_move pulse, illegal_code=10, next_side stays 1; then C(3,0) -> illegal_code=01.
REQ-043 N=3: P(0,0), then P(0,1) -> illegal_code=11 and cell (0,1) stays EMPTY.
REQ-044 N=3: nine-move draw sequence -> tie=1, win=0, move_count=9; clear -> all outputs at reset values next cycle.
REQ-045 N=5, K=4: anti-diagonal C(0,4),(1,3),(2,2),(3,1) with interleaved P moves -> win=1, winner=10; CHECK duration <= 24 cycles.
REQ-046 With MNK_GAME_UNDO_EN: winning move, then undo -> win=0, cell EMPTY, move_count decremented, move_ready=1.

Source files
------------

// File: rtl/mnk_game_if.sv
// rtl/mnk_game_if.sv - move request handshake bundle for mnk_game
interface mnk_game_if #(parameter int CW = 3);
  logic          move_valid;
  logic          move_ready;
  logic          move_side;
  logic [CW-1:0] move_row;
  logic [CW-1:0] move_col;

  modport master (output move_valid, move_side, move_row, move_col, input move_ready);
  modport slave  (input move_valid, move_side, move_row, move_col, output move_ready);
endinterface

// File: rtl/mnk_game.sv
// rtl/mnk_game.sv - m,n,k game referee: move checking, line scan, win/tie detection
// Optional single-level undo enabled by MNK_GAME_UNDO_EN.
module mnk_game #(
  parameter int N  = 3,
  parameter int K  = 3,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  mnk_game_if.slave     mv,
`ifdef MNK_GAME_UNDO_EN
  input  logic          undo,
`endif
  input  logic          clear,
  input  logic [CW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [1:0]    rd_cell,
  output logic          illegal_move,
  output logic [1:0]    illegal_code,
  output logic          win,
  output logic [1:0]    winner,
  output logic          tie,
  output logic [6:0]    move_count,
  output logic          next_side
);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, OVER = 2'd2} state_t;

  localparam int          SW    = CW + 2;
  localparam logic [6:0]  CELLS = 7'(N * N);

  state_t state, state_next;
  logic [1:0] board [N][N];

  logic [CW-1:0]        anc_row, anc_col;
  logic signed [SW-1:0] cur_row, cur_col, base_r, base_c, step_r, step_c, probe_r, probe_c;
  logic [1:0]           dir;
  logic                 neg, scan_side;
  logic [3:0]           run;

  logic hs, bad_off, bad_occ, bad_turn, accept, reject;
  logic in_board, match;
  logic [1:0] side_code;
  logic do_win, do_tie, scan_step, scan_turn, scan_next_dir;

  function automatic logic [1:0] cell_at(input logic [CW-1:0] r, input logic [CW-1:0] c);
    cell_at = 2'b00;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (r == i[CW-1:0] && c == j[CW-1:0]) cell_at = board[i][j];
  endfunction

  assign rd_cell       = cell_at(rd_row, rd_col);
  assign mv.move_ready = (state == IDLE);
  assign hs            = mv.move_valid && (state == IDLE);

  assign bad_off  = ({1'b0, mv.move_row} >= (CW+1)'(N)) || ({1'b0, mv.move_col} >= (CW+1)'(N));
  assign bad_occ  = !bad_off && (cell_at(mv.move_row, mv.move_col) != 2'b00);
  assign bad_turn = (mv.move_side != next_side);
  assign accept   = hs && !clear && !(bad_off || bad_occ || bad_turn);
  assign reject   = hs && !clear &&  (bad_off || bad_occ || bad_turn);

  // Directions: 0 row (0,+1), 1 column (+1,0), 2 diagonal (+1,+1), 3 anti-diagonal (+1,-1)
  assign base_r  = (dir == 2'd0) ? '0 : SW'(1);
  assign base_c  = (dir == 2'd1) ? '0 : ((dir == 2'd3) ? -SW'(1) : SW'(1));
  assign step_r  = neg ? -base_r : base_r;
  assign step_c  = neg ? -base_c : base_c;
  assign probe_r = cur_row + step_r;
  assign probe_c = cur_col + step_c;

  assign in_board  = !probe_r[SW-1] && !probe_c[SW-1] &&
                     (probe_r[SW-2:0] < (SW-1)'(N)) && (probe_c[SW-2:0] < (SW-1)'(N));
  assign side_code = scan_side ? 2'b10 : 2'b01;
  assign match     = in_board && (cell_at(probe_r[CW-1:0], probe_c[CW-1:0]) == side_code);

`ifdef MNK_GAME_UNDO_EN
  logic undo_armed, undo_ok;
  assign undo_ok = undo && !clear && !hs && undo_armed && (move_count != 7'd0) &&
                   ((state == IDLE) || (state == OVER));
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    do_win        = 1'b0;
    do_tie        = 1'b0;
    scan_step     = 1'b0;
    scan_turn     = 1'b0;
    scan_next_dir = 1'b0;
    case (state)
      IDLE:  if (accept) state_next = CHECK;
      CHECK: begin
        if (match) begin
          if (run >= 4'(K - 1)) begin
            do_win     = 1'b1;
            state_next = OVER;
          end else begin
            scan_step = 1'b1;
          end
        end else if (!neg) begin
          scan_turn = 1'b1;
        end else if (dir != 2'd3) begin
          scan_next_dir = 1'b1;
        end else if (move_count == CELLS) begin
          do_tie     = 1'b1;
          state_next = OVER;
        end else begin
          state_next = IDLE;
        end
      end
      OVER:    state_next = OVER;
      default: state_next = IDLE;
    endcase
`ifdef MNK_GAME_UNDO_EN
    if (undo_ok) state_next = IDLE;
`endif
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) board[i][j] <= 2'b00;
      move_count   <= 7'd0;
      next_side    <= 1'b0;
      illegal_move <= 1'b0;
      illegal_code <= 2'b00;
      win          <= 1'b0;
      winner       <= 2'b00;
      tie          <= 1'b0;
      anc_row      <= '0;
      anc_col      <= '0;
      cur_row      <= '0;
      cur_col      <= '0;
      dir          <= 2'd0;
      neg          <= 1'b0;
      run          <= 4'd0;
      scan_side    <= 1'b0;
`ifdef MNK_GAME_UNDO_EN
      undo_armed   <= 1'b0;
`endif
    end else if (clear) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) board[i][j] <= 2'b00;
      move_count   <= 7'd0;
      next_side    <= 1'b0;
      illegal_move <= 1'b0;
      illegal_code <= 2'b00;
      win          <= 1'b0;
      winner       <= 2'b00;
      tie          <= 1'b0;
`ifdef MNK_GAME_UNDO_EN
      undo_armed   <= 1'b0;
`endif
    end else begin
      illegal_move <= reject;
      if (reject) illegal_code <= bad_off ? 2'b01 : (bad_occ ? 2'b10 : 2'b11);
      if (accept) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            if (mv.move_row == i[CW-1:0] && mv.move_col == j[CW-1:0])
              board[i][j] <= mv.move_side ? 2'b10 : 2'b01;
        move_count   <= move_count + 7'd1;
        next_side    <= ~next_side;
        illegal_code <= 2'b00;
        anc_row      <= mv.move_row;
        anc_col      <= mv.move_col;
        cur_row      <= SW'(mv.move_row);
        cur_col      <= SW'(mv.move_col);
        dir          <= 2'd0;
        neg          <= 1'b0;
        run          <= 4'd1;
        scan_side    <= mv.move_side;
`ifdef MNK_GAME_UNDO_EN
        undo_armed   <= 1'b1;
`endif
      end
      if (scan_step) begin
        cur_row <= probe_r;
        cur_col <= probe_c;
        run     <= run + 4'd1;
      end
      // Each direction restarts from the placed stone; run keeps the positive half.
      if (scan_turn || scan_next_dir) begin
        cur_row <= SW'(anc_row);
        cur_col <= SW'(anc_col);
        neg     <= scan_turn;
      end
      if (scan_next_dir) begin
        dir <= dir + 2'd1;
        run <= 4'd1;
      end
      if (do_win) begin
        win    <= 1'b1;
        winner <= side_code;
      end
      if (do_tie) tie <= 1'b1;
`ifdef MNK_GAME_UNDO_EN
      if (undo_ok) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            if (anc_row == i[CW-1:0] && anc_col == j[CW-1:0]) board[i][j] <= 2'b00;
        move_count <= move_count - 7'd1;
        next_side  <= ~next_side;
        win        <= 1'b0;
        winner     <= 2'b00;
        tie        <= 1'b0;
        undo_armed <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mnk_game.sv
// tb/tb_mnk_game.sv - directed self-checking bench for mnk_game (3x3 K=3 and 5x5 K=4)
module tb_mnk_game;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mnk_game_if #(.CW(3)) m3 ();
  mnk_game_if #(.CW(3)) m5 ();

  logic       clear3, clear5, undo3, undo5;
  logic [2:0] rd_row3, rd_col3, rd_row5, rd_col5;
  logic [1:0] rd_cell3, rd_cell5, code3, code5, winner3, winner5;
  logic       ill3, ill5, win3, win5, tie3, tie5, ns3, ns5;
  logic [6:0] cnt3, cnt5;

  mnk_game #(.N(3), .K(3), .CW(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .mv(m3.slave),
`ifdef MNK_GAME_UNDO_EN
    .undo(undo3),
`endif
    .clear(clear3), .rd_row(rd_row3), .rd_col(rd_col3), .rd_cell(rd_cell3),
    .illegal_move(ill3), .illegal_code(code3), .win(win3), .winner(winner3),
    .tie(tie3), .move_count(cnt3), .next_side(ns3)
  );

  mnk_game #(.N(5), .K(4), .CW(3)) u_dut5 (
    .clk(clk), .rstn(rstn), .mv(m5.slave),
`ifdef MNK_GAME_UNDO_EN
    .undo(undo5),
`endif
    .clear(clear5), .rd_row(rd_row5), .rd_col(rd_col5), .rd_cell(rd_cell5),
    .illegal_move(ill5), .illegal_code(code5), .win(win5), .winner(winner5),
    .tie(tie5), .move_count(cnt5), .next_side(ns5)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic play(input bit big, input logic side, input logic [2:0] r,
                      input logic [2:0] c, output int cyc);
    int n = 0;
    while (!(big ? m5.move_ready : m3.move_ready) && n < 64) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 64) check("ready_timeout", 0, 1);
    if (big) begin
      m5.move_valid = 1'b1; m5.move_side = side; m5.move_row = r; m5.move_col = c;
    end else begin
      m3.move_valid = 1'b1; m3.move_side = side; m3.move_row = r; m3.move_col = c;
    end
    @(posedge clk); #1;
    m3.move_valid = 1'b0;
    m5.move_valid = 1'b0;
    cyc = 0;
    while (!(big ? (m5.move_ready | win5 | tie5) : (m3.move_ready | win3 | tie3)) && cyc < 64) begin
      @(posedge clk); #1; cyc++;
    end
    if (cyc >= 64) check("scan_timeout", 0, 1);
  endtask

  task automatic peek3(input logic [2:0] r, input logic [2:0] c, output logic [1:0] v);
    rd_row3 = r; rd_col3 = c; #1; v = rd_cell3;
  endtask

  task automatic clear_game3();
    clear3 = 1'b1; @(posedge clk); #1; clear3 = 1'b0;
  endtask

  task automatic check_idle3(input string tag);
    logic [1:0] v;
    check({tag, "_ready"}, m3.move_ready, 1);
    check({tag, "_win"}, win3, 0);
    check({tag, "_winner"}, winner3, 0);
    check({tag, "_tie"}, tie3, 0);
    check({tag, "_count"}, cnt3, 0);
    check({tag, "_next"}, ns3, 0);
    check({tag, "_ill"}, ill3, 0);
    check({tag, "_code"}, code3, 0);
    peek3(3'd1, 3'd1, v);
    check({tag, "_cell11"}, v, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [1:0] v;
    rstn = 1'b0;
    clear3 = 0; clear5 = 0; undo3 = 0; undo5 = 0;
    rd_row3 = 0; rd_col3 = 0; rd_row5 = 0; rd_col5 = 0;
    m3.move_valid = 0; m3.move_side = 0; m3.move_row = 0; m3.move_col = 0;
    m5.move_valid = 0; m5.move_side = 0; m5.move_row = 0; m5.move_col = 0;
    #3;
    check_idle3("reset");
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // Row win for PLAYER along row 0
    play(0, 0, 3'd0, 3'd0, cyc);
    play(0, 1, 3'd1, 3'd0, cyc);
    play(0, 0, 3'd0, 3'd1, cyc);
    play(0, 1, 3'd1, 3'd1, cyc);
    check("pre_win", win3, 0);
    play(0, 0, 3'd0, 3'd2, cyc);
    check("win_flag", win3, 1);
    check("win_winner", winner3, 2'b01);
    check("win_ready", m3.move_ready, 0);
    check("win_tie", tie3, 0);
    check("win_count", cnt3, 5);

    // Moves while OVER are ignored silently
    m3.move_valid = 1; m3.move_side = 1; m3.move_row = 3'd2; m3.move_col = 3'd2;
    @(posedge clk); #1;
    m3.move_valid = 0;
    check("over_ill", ill3, 0);
    check("over_count", cnt3, 5);
    peek3(3'd2, 3'd2, v);
    check("over_cell", v, 0);

`ifdef MNK_GAME_UNDO_EN
    undo3 = 1; @(posedge clk); #1; undo3 = 0;
    check("undo_win", win3, 0);
    check("undo_winner", winner3, 0);
    check("undo_count", cnt3, 4);
    check("undo_ready", m3.move_ready, 1);
    check("undo_next", ns3, 0);
    peek3(3'd0, 3'd2, v);
    check("undo_cell", v, 0);
    undo3 = 1; @(posedge clk); #1; undo3 = 0;
    check("undo2_count", cnt3, 4);
    peek3(3'd0, 3'd1, v);
    check("undo2_cell", v, 2'b01);
`endif

    clear_game3();
    check_idle3("clear1");

    // Occupied then off-board rejections
    play(0, 0, 3'd1, 3'd1, cyc);
    play(0, 1, 3'd1, 3'd1, cyc);
    check("occ_ill", ill3, 1);
    check("occ_code", code3, 2'b10);
    check("occ_next", ns3, 1);
    @(posedge clk); #1;
    check("occ_pulse_end", ill3, 0);
    check("occ_code_held", code3, 2'b10);
    play(0, 1, 3'd3, 3'd0, cyc);
    check("off_ill", ill3, 1);
    check("off_code", code3, 2'b01);
    check("off_count", cnt3, 1);
    peek3(3'd1, 3'd1, v);
    check("occ_cell", v, 2'b01);

    // Wrong turn
    clear_game3();
    play(0, 0, 3'd0, 3'd0, cyc);
    play(0, 0, 3'd0, 3'd1, cyc);
    check("turn_code", code3, 2'b11);
    check("turn_ill", ill3, 1);
    check("turn_count", cnt3, 1);
    peek3(3'd0, 3'd1, v);
    check("turn_cell", v, 0);

    // Nine-move draw: P C P / P C C / C P P
    clear_game3();
    play(0, 0, 3'd0, 3'd0, cyc);
    play(0, 1, 3'd0, 3'd1, cyc);
    play(0, 0, 3'd0, 3'd2, cyc);
    play(0, 1, 3'd1, 3'd1, cyc);
    play(0, 0, 3'd1, 3'd0, cyc);
    play(0, 1, 3'd1, 3'd2, cyc);
    play(0, 0, 3'd2, 3'd1, cyc);
    play(0, 1, 3'd2, 3'd0, cyc);
    check("draw_tie_early", tie3, 0);
    play(0, 0, 3'd2, 3'd2, cyc);
    check("draw_tie", tie3, 1);
    check("draw_win", win3, 0);
    check("draw_count", cnt3, 9);
    check("draw_ready", m3.move_ready, 0);
    clear_game3();
    check_idle3("clear2");

    // Reset in the middle of a scan
    m3.move_valid = 1; m3.move_side = 0; m3.move_row = 3'd0; m3.move_col = 3'd0;
    @(posedge clk); #1;
    m3.move_valid = 0;
    check("midscan_busy", m3.move_ready, 0);
    rstn = 1'b0; #1;
    check_idle3("midscan_rst");
    peek3(3'd0, 3'd0, v);
    check("midscan_cell", v, 0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // 5x5, K=4: COMPUTER anti-diagonal
    play(1, 0, 3'd0, 3'd0, cyc);
    play(1, 1, 3'd0, 3'd4, cyc);
    play(1, 0, 3'd1, 3'd0, cyc);
    play(1, 1, 3'd1, 3'd3, cyc);
    play(1, 0, 3'd2, 3'd0, cyc);
    play(1, 1, 3'd2, 3'd2, cyc);
    play(1, 0, 3'd4, 3'd4, cyc);
    check("n5_pre_win", win5, 0);
    play(1, 1, 3'd3, 3'd1, cyc);
    check("n5_win", win5, 1);
    check("n5_winner", winner5, 2'b10);
    check("n5_tie", tie5, 0);
    check("n5_scan_len", (cyc <= 24), 1);
    check("n5_count", cnt5, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
